// File: rtl/mux_4x1_8bits_pkg.sv
// Shared constants and state encoding for the 4-lane to 1-byte merge block.
// Imported by the lane-merge top and its priority-encoder helper.
package mux_4x1_8bits_pkg;

   localparam int LANES      = 4;
   localparam int LANE_IDX_W = 2;

   localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

endpackage

// File: rtl/mux_4x1_8bits_first_set_4.sv
// Priority encoder over the 4-lane mask: picks the lowest set lane and
// reports whether any lane is set and whether it is the only one left.
module first_set_4
   import mux_4x1_8bits_pkg::*;
(
   input  logic [LANES-1:0]      mask_i,
   output logic [LANE_IDX_W-1:0] idx_o,
   output logic                  any_o,
   output logic                  isLast_o
);

   // Scan from the top lane down so the lowest set lane wins.
   always_comb begin
      idx_o = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_o = LANE_IDX_W'(i);
         end
      end
   end

   assign any_o    = |mask_i;
   assign isLast_o = any_o && ((mask_i & (mask_i - LANES'(1))) == '0);

endmodule

// File: rtl/mux_4x1_8bits.sv
// Lane-merge: re-serializes up to four valid lane bytes per group onto one
// byte stream in ascending lane order, double-buffered for gapless streaming.
module mux_4x1_8bits
   import mux_4x1_8bits_pkg::*;
#(
   parameter int               DATA_W    = 8,
   parameter logic [DATA_W-1:0] IDLE_BYTE = DATA_W'(IDLE_BYTE_DEFAULT)
)
(
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic [DATA_W-1:0]     data_in0,
   input  logic [DATA_W-1:0]     data_in1,
   input  logic [DATA_W-1:0]     data_in2,
   input  logic [DATA_W-1:0]     data_in3,
   input  logic                  valid_in0,
   input  logic                  valid_in1,
   input  logic                  valid_in2,
   input  logic                  valid_in3,
   output logic                  in_ready,
   output logic [DATA_W-1:0]     data_out,
   output logic                  valid_out,
   output logic [LANE_IDX_W-1:0] lane_id
);

   state_e                           state_q, state_d;
   logic [LANES-1:0][DATA_W-1:0]     activeData_q, activeData_d;
   logic [LANES-1:0]                 activeMask_q, activeMask_d;
   logic [LANES-1:0][DATA_W-1:0]     pendData_q, pendData_d;
   logic [LANES-1:0]                 pendMask_q, pendMask_d;
   logic                             pendFull_q, pendFull_d;
   logic [DATA_W-1:0]                dataOut_q, dataOut_d;
   logic                             validOut_q, validOut_d;
   logic [LANE_IDX_W-1:0]            laneId_q, laneId_d;

   logic [LANES-1:0][DATA_W-1:0]     inData;
   logic [LANES-1:0]                 inMask;
   logic                             accept;
   logic [LANE_IDX_W-1:0]            firstIdx;
   logic                             firstAny;
   logic                             firstIsLast;
   logic [LANES-1:0]                 clearBit;

   assign inData   = {data_in3, data_in2, data_in1, data_in0};
   assign inMask   = {valid_in3, valid_in2, valid_in1, valid_in0};
   assign in_ready = !pendFull_q;
   assign accept   = in_ready && (|inMask);
   assign clearBit = LANES'(1) << firstIdx;

   first_set_4 u_firstSet (
      .mask_i   (activeMask_q),
      .idx_o    (firstIdx),
      .any_o    (firstAny),
      .isLast_o (firstIsLast)
   );

   // Emit one byte per cycle; on the last byte, refill active from pending
   // first, else bypass a freshly accepted group so streams stay gapless.
   always_comb begin
      state_d      = state_q;
      activeData_d = activeData_q;
      activeMask_d = activeMask_q;
      pendData_d   = pendData_q;
      pendMask_d   = pendMask_q;
      pendFull_d   = pendFull_q;
      dataOut_d    = IDLE_BYTE;
      validOut_d   = 1'b0;
      laneId_d     = '0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               activeData_d = inData;
               activeMask_d = inMask;
               state_d      = ST_SEND;
            end
         end
         ST_SEND: begin
            if (firstAny) begin
               dataOut_d    = activeData_q[firstIdx];
               validOut_d   = 1'b1;
               laneId_d     = firstIdx;
               activeMask_d = activeMask_q & ~clearBit;
               if (!firstIsLast) begin
                  if (accept) begin
                     pendData_d = inData;
                     pendMask_d = inMask;
                     pendFull_d = 1'b1;
                  end
               end else if (pendFull_q) begin
                  activeData_d = pendData_q;
                  activeMask_d = pendMask_q;
                  pendMask_d   = '0;
                  pendFull_d   = 1'b0;
               end else if (accept) begin
                  activeData_d = inData;
                  activeMask_d = inMask;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // All state is cleared asynchronously so no stale bytes survive a reset.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q      <= ST_IDLE;
         activeData_q <= '0;
         activeMask_q <= '0;
         pendData_q   <= '0;
         pendMask_q   <= '0;
         pendFull_q   <= 1'b0;
         dataOut_q    <= IDLE_BYTE;
         validOut_q   <= 1'b0;
         laneId_q     <= '0;
      end else begin
         state_q      <= state_d;
         activeData_q <= activeData_d;
         activeMask_q <= activeMask_d;
         pendData_q   <= pendData_d;
         pendMask_q   <= pendMask_d;
         pendFull_q   <= pendFull_d;
         dataOut_q    <= dataOut_d;
         validOut_q   <= validOut_d;
         laneId_q     <= laneId_d;
      end
   end

   assign data_out  = dataOut_q;
   assign valid_out = validOut_q;
   assign lane_id   = laneId_q;

endmodule

// File: tb/tb_mux_4x1_8bits.sv
// Self-checking bench for the lane-merge block: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mux_4x1_8bits;

   logic       clk = 1'b0;
   logic       reset_L;
   logic [7:0] d0, d1, d2, d3;
   logic       v0, v1, v2, v3;
   logic       in_ready;
   logic [7:0] data_out;
   logic       valid_out;
   logic [1:0] lane_id;

   int total = 0;
   int bad   = 0;
   bit checkOn = 1'b0;

   typedef struct {
      logic [1:0] lane;
      logic [7:0] data;
   } ent_t;

   ent_t activeQ[$];
   ent_t pendQ[$];
   bit   pendFull;

   logic [7:0] expData;
   logic       expValid;
   logic [1:0] expLane;
   logic       expReady;

   mux_4x1_8bits dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .data_in0  (d0),
      .data_in1  (d1),
      .data_in2  (d2),
      .data_in3  (d3),
      .valid_in0 (v0),
      .valid_in1 (v1),
      .valid_in2 (v2),
      .valid_in3 (v3),
      .in_ready  (in_ready),
      .data_out  (data_out),
      .valid_out (valid_out),
      .lane_id   (lane_id)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model by the rules of the merge,
   // and publish the expected registered outputs once the edge has happened.
   task automatic applyStimulus(input logic [3:0] vmask, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] e);
      ent_t       grp[$];
      ent_t       ent;
      logic [7:0] bytes[4];
      bit         accept;
      logic [7:0] nD = 8'h00;
      logic       nV = 1'b0;
      logic [1:0] nL = 2'd0;
      bytes = '{a, b, c, e};
      {v3, v2, v1, v0} = vmask;
      d0 = a; d1 = b; d2 = c; d3 = e;
      accept = !pendFull && (vmask != 4'd0);
      for (int i = 0; i < 4; i++) begin
         if (vmask[i]) begin
            ent.lane = 2'(i);
            ent.data = bytes[i];
            grp.push_back(ent);
         end
      end
      if (activeQ.size() == 0) begin
         if (accept) activeQ = grp;
      end else begin
         ent = activeQ.pop_front();
         nD = ent.data; nV = 1'b1; nL = ent.lane;
         if (activeQ.size() != 0) begin
            if (accept) begin
               pendQ = grp;
               pendFull = 1'b1;
            end
         end else if (pendFull) begin
            activeQ = pendQ;
            pendQ.delete();
            pendFull = 1'b0;
         end else if (accept) begin
            activeQ = grp;
         end
      end
      @(posedge clk);
      expData = nD; expValid = nV; expLane = nL; expReady = !pendFull;
      #2;
   endtask

   task automatic idleStep();
      applyStimulus(4'd0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic doReset(input int cycles);
      reset_L = 1'b0;
      activeQ.delete();
      pendQ.delete();
      pendFull = 1'b0;
      expData = 8'h00; expValid = 1'b0; expLane = 2'd0; expReady = 1'b1;
      {v3, v2, v1, v0} = 4'd0;
      repeat (cycles) @(posedge clk);
      #2;
      reset_L = 1'b1;
   endtask

   // Per-cycle comparison against the reference model, away from the active edge.
   always @(negedge clk) begin
      if (checkOn) begin
         checkOutput("model_valid", 32'(valid_out), 32'(expValid));
         checkOutput("model_data",  32'(data_out),  32'(expData));
         checkOutput("model_lane",  32'(lane_id),   32'(expLane));
         checkOutput("model_ready", 32'(in_ready),  32'(expReady));
      end
   end

   initial begin
      logic [7:0] full1[4];
      logic [7:0] bypassGrp[4];
      logic [7:0] seq[$];
      logic [7:0] g[3][4];
      logic [3:0] m;

      d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;
      pendFull = 1'b0;
      doReset(0);
      reset_L = 1'b0;
      checkOn = 1'b1;
      doReset(2);
      checkOutput("reset_valid", 32'(valid_out), 32'd0);
      checkOutput("reset_data",  32'(data_out),  32'h00);
      checkOutput("reset_ready", 32'(in_ready),  32'd1);

      // Single full group.
      full1 = '{8'h11, 8'h22, 8'h33, 8'h44};
      applyStimulus(4'hF, 8'h11, 8'h22, 8'h33, 8'h44);
      for (int k = 0; k < 4; k++) begin
         idleStep();
         checkOutput("full_valid", 32'(valid_out), 32'd1);
         checkOutput("full_data",  32'(data_out),  32'(full1[k]));
         checkOutput("full_lane",  32'(lane_id),   32'(k));
      end
      idleStep();
      checkOutput("full_end_valid", 32'(valid_out), 32'd0);
      checkOutput("full_end_data",  32'(data_out),  32'h00);

      // Sparse group on lanes 1 and 3.
      applyStimulus(4'b1010, 8'hEE, 8'h5A, 8'hEE, 8'hC3);
      idleStep();
      checkOutput("sparse_b0", 32'(data_out), 32'h5A);
      checkOutput("sparse_l0", 32'(lane_id),  32'd1);
      idleStep();
      checkOutput("sparse_b1", 32'(data_out), 32'hC3);
      checkOutput("sparse_l1", 32'(lane_id),  32'd3);
      idleStep();
      checkOutput("sparse_end", 32'(valid_out), 32'd0);

      // All-invalid groups never get accepted.
      for (int k = 0; k < 10; k++) begin
         idleStep();
         checkOutput("inval_valid", 32'(valid_out), 32'd0);
         checkOutput("inval_ready", 32'(in_ready),  32'd1);
      end

      // Continuous streaming of three full groups.
      for (int gi = 0; gi < 3; gi++) begin
         for (int l = 0; l < 4; l++) begin
            g[gi][l] = 8'(16 * (gi + 1) + l + 1);
            seq.push_back(g[gi][l]);
         end
      end
      for (int e = 0; e <= 12; e++) begin
         if (e == 0)      applyStimulus(4'hF, g[0][0], g[0][1], g[0][2], g[0][3]);
         else if (e == 1) applyStimulus(4'hF, g[1][0], g[1][1], g[1][2], g[1][3]);
         else if (e <= 5) applyStimulus(4'hF, g[2][0], g[2][1], g[2][2], g[2][3]);
         else             idleStep();
         if (e >= 1) begin
            checkOutput("stream_valid", 32'(valid_out), 32'd1);
            checkOutput("stream_data",  32'(data_out),  32'(seq[e-1]));
         end
         if (e == 1 || e == 3 || e == 5) checkOutput("stream_ready_lo", 32'(in_ready), 32'd0);
         if (e == 4) checkOutput("stream_ready_hi", 32'(in_ready), 32'd1);
      end
      idleStep();
      checkOutput("stream_end", 32'(valid_out), 32'd0);

      // Bypass on the last byte of a one-lane group.
      bypassGrp = '{8'h01, 8'h02, 8'h03, 8'h04};
      applyStimulus(4'b0100, 8'h00, 8'h00, 8'h7E, 8'h00);
      applyStimulus(4'hF, 8'h01, 8'h02, 8'h03, 8'h04);
      checkOutput("bypass_first", 32'(data_out), 32'h7E);
      checkOutput("bypass_lane",  32'(lane_id),  32'd2);
      for (int k = 0; k < 4; k++) begin
         idleStep();
         checkOutput("bypass_valid", 32'(valid_out), 32'd1);
         checkOutput("bypass_data",  32'(data_out),  32'(bypassGrp[k]));
      end
      idleStep();

      // Reset in the middle of a group.
      applyStimulus(4'hF, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
      idleStep();
      idleStep();
      checkOutput("rst_pre_data", 32'(data_out), 32'hB2);
      reset_L = 1'b0;
      #1;
      checkOutput("rst_async_valid", 32'(valid_out), 32'd0);
      checkOutput("rst_async_data",  32'(data_out),  32'h00);
      checkOutput("rst_async_ready", 32'(in_ready),  32'd1);
      doReset(2);
      for (int k = 0; k < 6; k++) begin
         idleStep();
         checkOutput("rst_no_residue", 32'(valid_out), 32'd0);
      end

      // Randomized traffic with one reset in the middle.
      for (int k = 0; k < 400; k++) begin
         m = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom);
         applyStimulus(m, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         if (k == 200) doReset(1);
      end
      repeat (10) idleStep();

      checkOn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
